// File: rtl/bcd_serial_inc_ctrl_if.sv
// Request/status bundle for the serial BCD incrementer.
// The master issues start/load requests; the slave returns the held value
// and the sequence status flags.
interface bcd_serial_inc_ctrl_if;
    logic        start;
    logic        load;
    logic [11:0] load_val;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic        overflow;

    modport master (
        output start, load, load_val,
        input  bcd, busy, done, overflow
    );

    modport slave (
        input  start, load, load_val,
        output bcd, busy, done, overflow
    );
endinterface

// File: rtl/bcd_serial_inc_ctrl.sv
// Three-digit BCD register with a serial incrementer.
// One shared single-digit incrementor is stepped across the digits, LSD
// first, one digit per clock, stopping as soon as no carry ripples on.
// WRAP selects what happens at 999: wrap to 000 or saturate.
module bcd_serial_inc_ctrl #(
    parameter bit WRAP = 1'b1
) (
    input logic                  clk,
    input logic                  reset_n,
    bcd_serial_inc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;

    logic [3:0]  cur_digit;
    logic [3:0]  nxt_digit;
    logic        carry;
    logic        all_nines;

    // Select the digit the shared incrementor works on this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        cur_digit = bcd_q[3:0];
        case (idx)
            2'd1:    cur_digit = bcd_q[7:4];
            2'd2:    cur_digit = bcd_q[11:8];
            default: cur_digit = bcd_q[3:0];
        endcase
    end

    // Shared one-digit incrementor; codes 9..15 all roll to 0 with carry.
    always_comb begin
        nxt_digit = 4'd0;
        carry     = 1'b1;
        if (cur_digit < 4'd9) begin
            nxt_digit = cur_digit + 4'd1;
            carry     = 1'b0;
        end
    end

    // Value that would carry out of the top digit on the next increment.
    assign all_nines = (bcd_q[3:0] >= 4'd9) && (bcd_q[7:4] >= 4'd9) &&
                       (bcd_q[11:8] >= 4'd9);

    // Control FSM with the held value and all status outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= 2'd0;
            bcd_q  <= 12'h000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    if (bus.load) begin
                        // load has priority; a simultaneous start is dropped
                        bcd_q <= bus.load_val;
                    end else if (bus.start) begin
                        if (!WRAP && all_nines) begin
                            // saturate: skip the digit walk entirely
                            state  <= DONE;
                            done_q <= 1'b1;
                            ovf_q  <= 1'b1;
                        end else begin
                            state  <= INC;
                            idx    <= 2'd0;
                            busy_q <= 1'b1;
                        end
                    end
                end

                INC: begin
                    case (idx)
                        2'd0:    bcd_q[3:0]  <= nxt_digit;
                        2'd1:    bcd_q[7:4]  <= nxt_digit;
                        default: bcd_q[11:8] <= nxt_digit;
                    endcase
                    if (!carry || idx == 2'd2) begin
                        state  <= DONE;
                        idx    <= 2'd0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // carry out of the top digit means we wrapped past 999
                        ovf_q  <= carry;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    idx    <= 2'd0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_serial_inc_ctrl.sv
// Self-checking bench for bcd_serial_inc_ctrl.
// A wrapping and a saturating instance receive identical stimulus.
// Index 1 of the per-instance arrays is the WRAP=1 instance, index 0 WRAP=0.
module tb_bcd_serial_inc_ctrl;

    logic clk;
    logic reset_n;

    bcd_serial_inc_ctrl_if if_w1 ();
    bcd_serial_inc_ctrl_if if_w0 ();

    bcd_serial_inc_ctrl #(.WRAP(1'b1)) dut_w1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_w1)
    );

    bcd_serial_inc_ctrl #(.WRAP(1'b0)) dut_w0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_w0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;
        logic [11:0] bcd1;
        int          done1;   // cycle after the start edge with done, WRAP=1
        logic        ovf1;
        logic [11:0] bcd0;
        int          done0;   // same for WRAP=0
        logic        ovf0;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int done_cyc [2];
    int busy_cnt [2];
    int done_cnt [2];
    int ovf_cnt  [2];
    int ovf_done [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ld, input logic [11:0] lv);
        if_w1.start = st; if_w1.load = ld; if_w1.load_val = lv;
        if_w0.start = st; if_w0.load = ld; if_w0.load_val = lv;
    endtask

    // Load a value; called and returns at a falling edge.
    task automatic do_load(input logic [11:0] v);
        drive(1'b0, 1'b1, v);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
    endtask

    task automatic sample(input int k);
        logic b [2];
        logic d [2];
        logic o [2];
        b[1] = if_w1.busy; d[1] = if_w1.done; o[1] = if_w1.overflow;
        b[0] = if_w0.busy; d[0] = if_w0.done; o[0] = if_w0.overflow;
        for (int w = 0; w < 2; w++) begin
            if (b[w]) busy_cnt[w]++;
            if (o[w]) ovf_cnt[w]++;
            if (d[w]) begin
                done_cnt[w]++;
                if (done_cyc[w] == 0) begin
                    done_cyc[w] = k;
                    ovf_done[w] = int'(o[w]);
                end
            end
        end
    endtask

    // Apply one request cycle, then watch a bounded number of cycles.
    // With poke set, start and load(0x555) are pulsed in cycle 1.
    task automatic run_seq(input logic st, input logic ld, input logic [11:0] lv,
                           input logic poke, input int cycles);
        for (int w = 0; w < 2; w++) begin
            done_cyc[w] = 0; busy_cnt[w] = 0; done_cnt[w] = 0;
            ovf_cnt[w] = 0; ovf_done[w] = 0;
        end
        drive(st, ld, lv);
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 1 && poke) drive(1'b1, 1'b1, 12'h555);
            else                drive(1'b0, 1'b0, 12'h000);
        end
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{12'h000, 12'h001, 2, 1'b0, 12'h001, 2, 1'b0};
        vecs[1] = '{12'h129, 12'h130, 3, 1'b0, 12'h130, 3, 1'b0};
        vecs[2] = '{12'h123, 12'h124, 2, 1'b0, 12'h124, 2, 1'b0};
        vecs[3] = '{12'h009, 12'h010, 3, 1'b0, 12'h010, 3, 1'b0};
        vecs[4] = '{12'h099, 12'h100, 4, 1'b0, 12'h100, 4, 1'b0};
        vecs[5] = '{12'h899, 12'h900, 4, 1'b0, 12'h900, 4, 1'b0};
        vecs[6] = '{12'h998, 12'h999, 2, 1'b0, 12'h999, 2, 1'b0};
        vecs[7] = '{12'h00F, 12'h010, 3, 1'b0, 12'h010, 3, 1'b0};
        vecs[8] = '{12'h999, 12'h000, 4, 1'b1, 12'h999, 1, 1'b1};

        // Reset with no activity.
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset bcd w1", 32'(if_w1.bcd), 32'h000);
        check("reset bcd w0", 32'(if_w0.bcd), 32'h000);
        check("reset busy", 32'({if_w1.busy, if_w0.busy}), 32'h0);
        check("reset done", 32'({if_w1.done, if_w0.done}), 32'h0);
        check("reset overflow", 32'({if_w1.overflow, if_w0.overflow}), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven increments on both instances.
        foreach (vecs[i]) begin
            do_load(vecs[i].val);
            check($sformatf("v%0d load w1", i), 32'(if_w1.bcd), 32'(vecs[i].val));
            run_seq(1'b1, 1'b0, 12'h000, 1'b0, 6);
            check($sformatf("v%0d bcd w1", i), 32'(if_w1.bcd), 32'(vecs[i].bcd1));
            check($sformatf("v%0d bcd w0", i), 32'(if_w0.bcd), 32'(vecs[i].bcd0));
            check($sformatf("v%0d done cycle w1", i), 32'(done_cyc[1]), 32'(vecs[i].done1));
            check($sformatf("v%0d done cycle w0", i), 32'(done_cyc[0]), 32'(vecs[i].done0));
            check($sformatf("v%0d done count w1", i), 32'(done_cnt[1]), 32'd1);
            check($sformatf("v%0d done count w0", i), 32'(done_cnt[0]), 32'd1);
            check($sformatf("v%0d busy cycles w1", i), 32'(busy_cnt[1]), 32'(vecs[i].done1 - 1));
            check($sformatf("v%0d busy cycles w0", i), 32'(busy_cnt[0]), 32'(vecs[i].done0 - 1));
            check($sformatf("v%0d ovf at done w1", i), 32'(ovf_done[1]), 32'(vecs[i].ovf1));
            check($sformatf("v%0d ovf at done w0", i), 32'(ovf_done[0]), 32'(vecs[i].ovf0));
            check($sformatf("v%0d ovf pulses w1", i), 32'(ovf_cnt[1]), 32'(vecs[i].ovf1));
            check($sformatf("v%0d ovf pulses w0", i), 32'(ovf_cnt[0]), 32'(vecs[i].ovf0));
        end

        // start and load pulsed while busy are both ignored.
        do_load(12'h099);
        run_seq(1'b1, 1'b0, 12'h000, 1'b1, 7);
        check("poke bcd w1", 32'(if_w1.bcd), 32'h100);
        check("poke bcd w0", 32'(if_w0.bcd), 32'h100);
        check("poke done count w1", 32'(done_cnt[1]), 32'd1);
        check("poke done cycle w1", 32'(done_cyc[1]), 32'd4);
        check("poke busy cycles w1", 32'(busy_cnt[1]), 32'd3);

        // load and start together: load wins, no increment sequence.
        run_seq(1'b1, 1'b1, 12'h042, 1'b0, 4);
        check("ld+st bcd w1", 32'(if_w1.bcd), 32'h042);
        check("ld+st bcd w0", 32'(if_w0.bcd), 32'h042);
        check("ld+st busy cycles", 32'(busy_cnt[1] + busy_cnt[0]), 32'd0);
        check("ld+st done count", 32'(done_cnt[1] + done_cnt[0]), 32'd0);

        // Reset in the second INC cycle aborts without a done pulse.
        do_load(12'h199);
        drive(1'b1, 1'b0, 12'h000);
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        @(negedge clk);
        check("abort busy before reset", 32'(if_w1.busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort bcd w1", 32'(if_w1.bcd), 32'h000);
        check("abort bcd w0", 32'(if_w0.bcd), 32'h000);
        check("abort busy", 32'({if_w1.busy, if_w0.busy}), 32'h0);
        check("abort done", 32'({if_w1.done, if_w0.done}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_seq(1'b0, 1'b0, 12'h000, 1'b0, 4);
        check("abort no done", 32'(done_cnt[1] + done_cnt[0]), 32'd0);
        check("abort idle busy", 32'(busy_cnt[1] + busy_cnt[0]), 32'd0);
        run_seq(1'b1, 1'b0, 12'h000, 1'b0, 5);
        check("resume bcd w1", 32'(if_w1.bcd), 32'h001);
        check("resume bcd w0", 32'(if_w0.bcd), 32'h001);
        check("resume done cycle w1", 32'(done_cyc[1]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_inc_ctrl.md
BCD_SERIAL_INC_CTRL -- requirements
Module: bcd_serial_inc_ctrl

Interface
REQ-001 Parameter: WRAP, default 1, overflow policy at 999 (1 = wrap to 000, 0 = saturate at 999).
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request one BCD increment of the held value; sampled on rising clk.
REQ-005 Port: load  input  1  replace the held value with load_val; sampled on rising clk.
REQ-006 Port: load_val  input  12  load value; [3:0] digit0 (LSD), [7:4] digit1, [11:8] digit2.
REQ-007 Port: bcd  output  12  registered held value, same digit packing as load_val.
REQ-008 Port: busy  output  1  high while a digit-increment sequence is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when an increment sequence completes.
REQ-010 Port: overflow  output  1  one-cycle pulse coincident with done when the increment crossed or hit 999.

Function
REQ-011 A single shared one-digit incrementor shall be time-multiplexed across the three digits, one digit per cycle; no parallel three-digit incrementor.
REQ-012 Digit rule: inc=1 and digit>=9 -> digit 0, carry 1; inc=1 and digit<9 -> digit+1, carry 0. Digit codes 10-15 therefore behave as 9.
REQ-013 FSM states: IDLE, INC (with 2-bit digit index 0..2), DONE.
REQ-014 IDLE: load=1 -> bcd<=load_val, stay IDLE. load=0 and start=1 -> INC, index 0. Otherwise stay.
REQ-015 INC: write the incremented digit[index] to its register. If carry=0 or index=2, go to DONE; otherwise index+1, stay INC.
REQ-016 DONE: lasts exactly one cycle with done=1, then returns to IDLE. start and load are ignored in DONE.
REQ-017 busy=1 in INC only; busy=0 in IDLE and DONE.
REQ-018 start and load are ignored while busy; there is no request queue and no error flag.
REQ-019 load and start asserted together in IDLE: load wins and start is dropped.
REQ-020 Latency: done is high N+1 cycles after the start-sampling edge, where N = number of INC cycles (1..3). N = 1 + count of consecutive low-order digits >= 9, capped at 3.
REQ-021 WRAP=1, value 999: three INC cycles give 000, and overflow=1 in the DONE cycle.
REQ-022 WRAP=0, value 999 at start: go directly IDLE->DONE with no INC cycles. bcd is unchanged, done and overflow both 1 the cycle after the start edge.
REQ-023 WRAP=0, value below 999: behaviour identical to WRAP=1 and overflow stays 0.
REQ-024 During INC, bcd reflects partial updates. bcd is valid only when busy=0.
REQ-025 Outputs bcd, busy, done and overflow shall all be registered, with no combinational path from inputs.

Reset
REQ-026 reset_n=0 shall immediately force: state IDLE, index 0, bcd=0x000, busy=0, done=0, overflow=0.
REQ-027 A reset asserted mid-sequence aborts the sequence with no done pulse. Operation resumes on the first rising clk after reset_n returns high.

Verification
REQ-028 Reset with no activity -> bcd=0x000, busy=0, done=0, overflow=0.
REQ-029 load 0x129, then start -> busy for 2 cycles, done 3 cycles after the start edge, bcd=0x130, overflow=0. Start from 0x000 -> done after 2 cycles, bcd=0x001.
REQ-030 WRAP=1: load 0x999, start -> busy 3 cycles, done and overflow high 4 cycles after the start edge, bcd=0x000. WRAP=0: same stimulus -> done and overflow 1 cycle after the start edge, bcd=0x999, busy never high.
REQ-031 load 0x099, start, then pulse start and load (load_val 0x555) during busy -> both ignored, single done, bcd=0x100.
REQ-032 load and start together in IDLE with load_val 0x042 -> bcd=0x042, busy stays 0, no done.
REQ-033 load 0x199, start, assert reset_n low on the second INC cycle -> bcd=0x000 at once, no done; a later start gives bcd=0x001.
